// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared FSM encoding and datapath widths for the
// adder arbiter and its sub-modules.
package adder_arbiter_pkg;

    localparam int OPND_W = 4;  // operand width of each requester
    localparam int SUM_W  = 5;  // operand width plus carry-out

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_arbiter_grant.sv
// adder_arbiter_grant: one-hot grant selection. The search starts at index
// ptr and wraps around; with ptr held at zero it degenerates into plain
// lowest-index-wins priority. Built from masks and priority scans only.
module adder_arbiter_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] at_or_above;
    logic [NUM_REQ-1:0] masked;
    logic               hit;

    // Thermometer mask of indices >= ptr: these are searched first.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign at_or_above[gi] = (ID_W'(gi) >= ptr);
        end
    endgenerate

    assign masked = req_valid & at_or_above;

    // Lowest set bit at/after ptr; if none, wrap to lowest set bit overall.
    always_comb begin
        grant = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && masked[i]) begin
                grant[i] = 1'b1;
                hit      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req_valid[i]) begin
                grant[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_adder4.sv
// ripple_adder4: 4-bit ripple-carry adder, no carry-in; out[4] is the
// carry-out. This is the only arithmetic used by the adder arbiter.
module ripple_adder4 (
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    output logic [4:0] out
);

    logic [4:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign out[gi]       = inA[gi] ^ inB[gi] ^ carry[gi];
            assign carry[gi + 1] = (inA[gi] & inB[gi]) | (carry[gi] & (inA[gi] ^ inB[gi]));
        end
    endgenerate

    assign out[4] = carry[4];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: NUM_REQ requesters share one 4-bit adder. IDLE accepts one
// operand pair, CALC registers the sum, RESP holds it until rsp_ready.
// Define ADDER_ARBITER_RR_EN for round-robin arbitration; otherwise the
// lowest requesting index always wins and no pointer register exists.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [SUM_W-1:0]          rsp_sum,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_t              state_reg;
    state_t              state_next;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_idx;
    logic [OPND_W-1:0]   sel_a;
    logic [OPND_W-1:0]   sel_b;
    logic [OPND_W-1:0]   a_reg;
    logic [OPND_W-1:0]   b_reg;
    logic [ID_W-1:0]     id_reg;
    logic [SUM_W-1:0]    sum_reg;
    logic [SUM_W-1:0]    adder_out;
    logic                accept;

    adder_arbiter_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant)
    );

    ripple_adder4 u_adder (
        .inA (a_reg),
        .inB (b_reg),
        .out (adder_out)
    );

    // Encode the one-hot grant and mux the winner's operands with AND-OR.
    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | ID_W'(i);
                sel_a     = sel_a | req_a[i*OPND_W +: OPND_W];
                sel_b     = sel_b | req_b[i*OPND_W +: OPND_W];
            end
        end
    end

    assign accept = (state_reg == IDLE) && (|grant);

`ifdef ADDER_ARBITER_RR_EN
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] grant_rot;

    // Rotating the one-hot grant up by one yields (g+1) mod NUM_REQ.
    assign grant_rot = {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};

    // Encode the rotated grant into the next search start.
    always_comb begin
        ptr_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_rot[i]) begin
                ptr_next = ptr_next | ID_W'(i);
            end
        end
    end

    // Advance the round-robin pointer past each accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (accept) begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one accept, one compute cycle, hold until consumed.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)    state_next = CALC;
            CALC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Outputs; req_ready is also gated by rst_n because it depends on the
    // live req_valid inputs, which reset alone would not silence.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (rst_n) begin
                    req_ready = grant;
                end
            end
            CALC: ;
            RESP: rsp_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: capture the winner on accept, register the sum in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            id_reg  <= '0;
            sum_reg <= '0;
        end else begin
            if (accept) begin
                a_reg  <= sel_a;
                b_reg  <= sel_b;
                id_reg <= grant_idx;
            end
            if (state_reg == CALC) begin
                sum_reg <= adder_out;
            end
        end
    end

    assign rsp_sum = sum_reg;
    assign rsp_id  = id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed stimulus with a response scoreboard. Issued
// transactions push their hand-computed {id, sum}; a monitor pops and
// compares on every rsp_valid && rsp_ready handshake.
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;

    int          checks;
    int          failures;
    int          cyc;
    logic [6:0]  exp_q[$];
    logic [6:0]  mon_e;

    adder_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Scoreboard monitor: one pop per completed response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual id=%0d sum=%0d expected no response", rsp_id, rsp_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_sum", 32'(rsp_sum), 32'(mon_e[4:0]));
                chk("rsp_id", 32'(rsp_id), 32'(mon_e[6:5]));
            end
        end
    end

    // Wait (bounded) for a non-zero req_ready and return its index.
    task automatic wait_grant(output int g, output int acc_cyc);
        bit ok;
        g = -1;
        ok = 1'b0;
        acc_cyc = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                ok = 1'b1;
                acc_cyc = cyc;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=no req_ready expected=req_ready within 20 cycles");
        end else begin
            chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        end
    endtask

    // Present one requester, check which one is granted, push expectation.
    task automatic issue(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input bit push, input logic [4:0] es, output int acc_cyc);
        int g;
        @(posedge clk);
        #1;
        req_valid[idx]   = 1'b1;
        req_a[idx*4 +: 4] = a;
        req_b[idx*4 +: 4] = b;
        wait_grant(g, acc_cyc);
        chk("grant_idx", 32'(g), 32'(idx));
        if (push) exp_q.push_back({2'(idx), es});
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int acc;
        int prev;
        logic [4:0] tbl_sum[4];
        int         exp_order[5];

        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tbl_sum   = '{5'd3, 5'd11, 5'd17, 5'd27};
`ifdef ADDER_ARBITER_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif

        // Reset state, with a request pending that must not be acknowledged.
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four valid continuously: grant order and 3-cycle spacing.
        req_a = {4'hE, 4'h9, 4'h5, 4'h1};
        req_b = {4'hD, 4'h8, 4'h6, 4'h2};
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, acc);
            chk("order_grant", 32'(g), 32'(exp_order[k]));
            exp_q.push_back({2'(exp_order[k]), tbl_sum[exp_order[k]]});
            if (k > 0) chk("accept_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);

        // Single request: same-cycle ready, two-cycle latency.
        issue(0, 4'd3, 4'd4, 1'b1, 5'd7, acc);
        @(negedge clk);
        chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("calc_busy", 32'(busy), 32'd1);
        chk("calc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(cyc - acc), 32'd2);
        repeat (3) @(negedge clk);

        // Carry-out cases, including the largest possible sum.
        issue(2, 4'hF, 4'h1, 1'b1, 5'h10, acc);
        repeat (4) @(negedge clk);
        issue(1, 4'hF, 4'hF, 1'b1, 5'h1E, acc);
        repeat (4) @(negedge clk);

        // Backpressure: response held 5 cycles, another request waits.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(3, 4'd7, 4'd8, 1'b1, 5'd15, acc);
        req_a[7:4]   = 4'd2;
        req_b[7:4]   = 4'd2;
        req_valid[1] = 1'b1;
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_sum", 32'(rsp_sum), 32'd15);
            chk("bp_rsp_id", 32'(rsp_id), 32'd3);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(g, acc);
        chk("bp_next_grant", 32'(g), 32'd1);
        exp_q.push_back({2'd1, 5'd4});
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (5) @(negedge clk);

        // Reset during CALC: everything clears at once, no response follows.
        issue(0, 4'd5, 4'd5, 1'b0, 5'd0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("async_rsp_id", 32'(rsp_id), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        issue(2, 4'd6, 4'd3, 1'b1, 5'd9, acc);
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
